// File: rtl/piano_track_scheduler.sv
// Multi-track note register: one active note plus a one-deep pending slot per track,
// with tick-based auto-release of timed notes. Feeds the tone generators via oTracks.
module piano_track_scheduler #(
   parameter  int TRACKS   = 4,
   parameter  int NOTE_W   = 6,
   parameter  int DUR_W    = 8,
   parameter  int TICK_DIV = 100000,
   localparam int TRK_W    = (TRACKS > 1) ? $clog2(TRACKS) : 1
) (
   input  logic                     iFpgaClock,
   input  logic                     iFpgaReset,
   input  logic                     iCmdValid,
   input  logic [TRK_W-1:0]         iCmdTrack,
   input  logic [NOTE_W-1:0]        iCmdNote,
   input  logic [DUR_W-1:0]         iCmdDur,
   input  logic                     iCmdQueue,
   input  logic                     iStopAll,
   output logic                     oCmdReady,
   output logic [TRACKS*NOTE_W-1:0] oTracks,
   output logic [TRACKS-1:0]        oBusy,
   output logic [TRACKS-1:0]        oDone
);
   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic                             tick;
   logic [TRACKS-1:0][NOTE_W-1:0]    note_q, note_d, pnote_q, pnote_d;
   logic [TRACKS-1:0][DUR_W-1:0]     remain_q, remain_d, pdur_q, pdur_d;
   logic [TRACKS-1:0]                busy_q, busy_d, sustain_q, sustain_d;
   logic [TRACKS-1:0]                pvalid_q, pvalid_d, done_q, done_d;
   logic [TRACKS-1:0]                sel, expire;
   logic                             cmd_acc;

   assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

   // Out-of-range track numbers select nothing, so the command is silently dropped.
   always_comb begin
      sel    = '0;
      expire = '0;
      for (int k = 0; k < TRACKS; k++) begin
         sel[k]    = (int'(iCmdTrack) == k);
         expire[k] = tick && busy_q[k] && !sustain_q[k] && (remain_q[k] == DUR_W'(1));
      end
   end

   assign oCmdReady = !(iCmdQueue && |(sel & busy_q & pvalid_q));
   assign cmd_acc   = iCmdValid && oCmdReady;

   always_comb begin
      note_d    = note_q;
      remain_d  = remain_q;
      busy_d    = busy_q;
      sustain_d = sustain_q;
      pnote_d   = pnote_q;
      pdur_d    = pdur_q;
      pvalid_d  = pvalid_q;
      done_d    = '0;
      for (int k = 0; k < TRACKS; k++) begin
         if (iStopAll) begin
            note_d[k]    = '0;
            remain_d[k]  = '0;
            busy_d[k]    = 1'b0;
            sustain_d[k] = 1'b0;
            pvalid_d[k]  = 1'b0;
         end else if (cmd_acc && sel[k] && !iCmdQueue) begin
            note_d[k]    = iCmdNote;
            busy_d[k]    = 1'b1;
            sustain_d[k] = (iCmdDur == '0);
            if (iCmdDur != '0) remain_d[k] = iCmdDur;
            pvalid_d[k]  = 1'b0;
         end else begin
            if (expire[k]) begin
               done_d[k] = 1'b1;
               if (pvalid_q[k]) begin
                  note_d[k]    = pnote_q[k];
                  busy_d[k]    = 1'b1;
                  sustain_d[k] = (pdur_q[k] == '0);
                  if (pdur_q[k] != '0) remain_d[k] = pdur_q[k];
                  pvalid_d[k]  = 1'b0;
               end else begin
                  note_d[k]   = '0;
                  busy_d[k]   = 1'b0;
                  remain_d[k] = '0;
               end
            end else if (tick && busy_q[k] && !sustain_q[k] && remain_q[k] > DUR_W'(1)) begin
               remain_d[k] = remain_q[k] - DUR_W'(1);
            end
            // A track freeing up this very cycle takes the queued command directly.
            if (cmd_acc && sel[k] && iCmdQueue) begin
               if (!busy_q[k] || (expire[k] && !pvalid_q[k])) begin
                  note_d[k]    = iCmdNote;
                  busy_d[k]    = 1'b1;
                  sustain_d[k] = (iCmdDur == '0);
                  if (iCmdDur != '0) remain_d[k] = iCmdDur;
               end else begin
                  pvalid_d[k] = 1'b1;
                  pnote_d[k]  = iCmdNote;
                  pdur_d[k]   = iCmdDur;
               end
            end
         end
      end
   end

   always_ff @(posedge iFpgaClock or posedge iFpgaReset) begin
      if (iFpgaReset) begin
         cnt_q     <= '0;
         note_q    <= '0;
         remain_q  <= '0;
         busy_q    <= '0;
         sustain_q <= '0;
         pnote_q   <= '0;
         pdur_q    <= '0;
         pvalid_q  <= '0;
         done_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         note_q    <= note_d;
         remain_q  <= remain_d;
         busy_q    <= busy_d;
         sustain_q <= sustain_d;
         pnote_q   <= pnote_d;
         pdur_q    <= pdur_d;
         pvalid_q  <= pvalid_d;
         done_q    <= done_d;
      end
   end

   assign oTracks = note_q;
   assign oBusy   = busy_q;
   assign oDone   = done_q;
endmodule

// File: tb/tb_piano_track_scheduler.sv
// Directed + random bench for piano_track_scheduler; reference model tracks absolute
// tick numbers for expiry rather than per-track countdowns.
module tb_piano_track_scheduler;
   localparam int TR = 4, NW = 6, DW = 8, TD = 4;

   logic           clk = 1'b0, rst = 1'b1;
   logic           v = 1'b0, q = 1'b0, stop = 1'b0;
   logic [1:0]     trk = '0;
   logic [NW-1:0]  note = '0;
   logic [DW-1:0]  dur = '0;
   logic           ready;
   logic [TR*NW-1:0] tracks;
   logic [TR-1:0]  busy, done;

   always #5 clk = ~clk;

   piano_track_scheduler #(.TRACKS(TR), .NOTE_W(NW), .DUR_W(DW), .TICK_DIV(TD)) dut (
      .iFpgaClock(clk), .iFpgaReset(rst), .iCmdValid(v), .iCmdTrack(trk),
      .iCmdNote(note), .iCmdDur(dur), .iCmdQueue(q), .iStopAll(stop),
      .oCmdReady(ready), .oTracks(tracks), .oBusy(busy), .oDone(done));

   int checks = 0, failures = 0;

   // Model: a timed note expires when the global tick count reaches m_exp.
   int m_note[TR], m_exp[TR], m_pn[TR], m_pd[TR];
   bit m_busy[TR], m_sus[TR], m_pv[TR], m_done[TR];
   int m_cyc, m_ticks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int k = 0; k < TR; k++) begin
         m_note[k] = 0; m_exp[k] = 0; m_pn[k] = 0; m_pd[k] = 0;
         m_busy[k] = 0; m_sus[k] = 0; m_pv[k] = 0; m_done[k] = 0;
      end
      m_cyc = 0; m_ticks = 0;
   endfunction

   function automatic void m_load(int k, int n, int d, int nt);
      m_note[k] = n; m_busy[k] = 1; m_sus[k] = (d == 0); m_exp[k] = nt + d;
   endfunction

   function automatic bit m_ready();
      return !(q && m_busy[trk] && m_pv[trk]);
   endfunction

   function automatic bit m_will_exp(int k);
      bit tk = (m_cyc % TD) == TD - 1;
      return tk && m_busy[k] && !m_sus[k] && m_exp[k] == m_ticks + 1;
   endfunction

   function automatic void m_edge();
      bit tk  = (m_cyc % TD) == TD - 1;
      int nt  = m_ticks + int'(tk);
      bit acc = v && m_ready();
      for (int k = 0; k < TR; k++) begin
         m_done[k] = 0;
         if (stop) begin
            m_note[k] = 0; m_busy[k] = 0; m_sus[k] = 0; m_pv[k] = 0;
         end else if (acc && !q && int'(trk) == k) begin
            m_load(k, int'(note), int'(dur), nt); m_pv[k] = 0;
         end else begin
            if (tk && m_busy[k] && !m_sus[k] && m_exp[k] == nt) begin
               m_done[k] = 1;
               if (m_pv[k]) begin m_load(k, m_pn[k], m_pd[k], nt); m_pv[k] = 0; end
               else begin m_busy[k] = 0; m_note[k] = 0; end
            end
            if (acc && q && int'(trk) == k) begin
               if (!m_busy[k]) m_load(k, int'(note), int'(dur), nt);
               else begin m_pv[k] = 1; m_pn[k] = int'(note); m_pd[k] = int'(dur); end
            end
         end
      end
      m_cyc++; m_ticks = nt;
   endfunction

   function automatic logic [TR*NW-1:0] m_tracks();
      logic [TR*NW-1:0] r = '0;
      for (int k = 0; k < TR; k++) r[k*NW +: NW] = NW'(m_note[k]);
      return r;
   endfunction

   function automatic logic [TR-1:0] m_vec(bit busy_sel);
      logic [TR-1:0] r = '0;
      for (int k = 0; k < TR; k++) r[k] = busy_sel ? m_busy[k] : m_done[k];
      return r;
   endfunction

   task automatic step(input bit iv, input int it, input int in, input int id,
                       input bit iq, input bit is);
      v = iv; trk = 2'(it); note = NW'(in); dur = DW'(id); q = iq; stop = is;
      #1;
      if (iv) chk("ready", 32'(ready), 32'(m_ready()));
      m_edge();
      @(posedge clk); #1;
      chk("tracks", 32'(tracks), 32'(m_tracks()));
      chk("busy", 32'(busy), 32'(m_vec(1)));
      chk("done", 32'(done), 32'(m_vec(0)));
      v = 1'b0; stop = 1'b0; q = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int n;
      m_reset();
      // 1: reset, then sustained override
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tracks", 32'(tracks), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(ready), 1);
      rst = 1'b0;
      step(1, 2, 13, 0, 0, 0);
      chk("t1_note", 32'(tracks[17:12]), 13);
      chk("t1_busy", 32'(busy), 32'h4);
      idle(100);
      chk("t1_hold", 32'(tracks[17:12]), 13);

      // 2: timed expiry, held between 9 and 12 cycles
      step(1, 0, 5, 3, 0, 0);
      n = 0;
      while (!done[0] && n < 20) begin idle(1); n++; end
      chk("t2_expired", 32'(n < 20), 1);
      chk("t2_hold_len", 32'(n >= 9 && n <= 12), 1);
      chk("t2_note0", 32'(tracks[5:0]), 0);
      chk("t2_busy0", 32'(busy[0]), 0);
      idle(1);
      chk("t2_done_once", 32'(done[0]), 0);

      // 3: queue behind a timed note, second queue refused
      step(1, 1, 7, 2, 0, 0);
      step(1, 1, 9, 1, 1, 0);
      v = 1'b1; trk = 2'd1; q = 1'b1; note = 6'd11; dur = 8'd1;
      #1;
      chk("t3_ready_low", 32'(ready), 0);
      step(1, 1, 11, 1, 1, 0);
      n = 0;
      while (!done[1] && n < 20) begin idle(1); n++; end
      chk("t3_handoff_note", 32'(tracks[11:6]), 9);
      chk("t3_handoff_busy", 32'(busy[1]), 1);
      idle(1);
      n = 0;
      while (!done[1] && n < 20) begin idle(1); n++; end
      chk("t3_second_done", 32'(done[1]), 1);
      chk("t3_note0", 32'(tracks[11:6]), 0);

      // 4: override in the exact expiry cycle
      while (m_cyc % TD != 0) idle(1);
      step(1, 3, 11, 1, 0, 0);
      step(1, 3, 12, 5, 1, 0);
      n = 0;
      while (!m_will_exp(3) && n < 12) begin idle(1); n++; end
      chk("t4_found_expiry", 32'(n < 12), 1);
      step(1, 3, 20, 2, 0, 0);
      chk("t4_note20", 32'(tracks[23:18]), 20);
      chk("t4_no_done", 32'(done[3]), 0);
      idle(12);
      chk("t4_pending_cleared", 32'(tracks[23:18]), 0);

      // 5: stop-all with a concurrent override
      for (int k = 0; k < TR; k++) begin
         step(1, k, k + 1, 0, 0, 0);
         step(1, k, k + 40, 3, 1, 0);
      end
      chk("t5_all_busy", 32'(busy), 32'hf);
      step(1, 1, 33, 2, 0, 1);
      chk("t5_tracks0", 32'(tracks), 0);
      chk("t5_busy0", 32'(busy), 0);
      chk("t5_done0", 32'(done), 0);
      idle(20);
      chk("t5_stays_idle", 32'(busy), 0);

      // 6: async reset between edges
      step(1, 0, 7, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_tracks", 32'(tracks), 0);
      chk("t6_async_busy", 32'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
      step(1, 0, 9, 1, 0, 0);
      idle(2);
      chk("t6_before_tick", 32'(busy[0]), 1);
      idle(1);
      chk("t6_first_tick", 32'(busy[0]), 0);
      chk("t6_first_done", 32'(done[0]), 1);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 1)), int'($urandom_range(0, TR - 1)),
              int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
